// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encodings
// and the default operand width.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder used as the single arithmetic step of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);

    assign s = a ^ b ^ cin;
    assign c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder step per RUN cycle, WIDTH steps per add.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CW-1:0]    count;
    logic             fa_s;
    logic             fa_c;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] load_b;
    logic             load_c;

    full_adder u_full_adder (
        .a   (op_a[0]),
        .b   (op_b[0]),
        .cin (carry),
        .s   (fa_s),
        .c   (fa_c)
    );

    // New sum bit enters at the MSB; the extra bit keeps WIDTH=1 well-formed.
    assign sum_ext = {fa_s, sum};

`ifdef SERIAL_ADDER_SUB_EN
    // a - b computed as a + ~b + 1; cout=1 then means no borrow.
    assign load_b = sub ? ~b : b;
    assign load_c = sub | cin;
`else
    logic sub_unused;
    assign sub_unused = sub;
    assign load_b     = b;
    assign load_c     = cin;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a  <= a;
                        op_b  <= load_b;
                        carry <= load_c;
                        sum   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum   <= sum_ext[WIDTH:1];
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    carry <= fa_c;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        cout  <= fa_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8); subtract
// vectors are exercised only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    logic             done;

    int total_checks;
    int passed_checks;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        assert (observed === expected) passed_checks++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Start pulse with operands; returns at the negedge after the accept edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic cv, input logic sv);
        @(negedge clk);
        a     = av;
        b     = bv;
        cin   = cv;
        sub   = sv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done, checking latency, busy duration and the result.
    task automatic runAdd(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic cv, input logic sv,
                          input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
        int lat;
        int busy_cnt;
        lat      = 0;
        busy_cnt = 0;
        applyStimulus(av, bv, cv, sv);
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(WIDTH));
        checkOutput({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(WIDTH));
        checkOutput({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        checkOutput({tag, "_cout"}, 32'(cout), 32'(exp_cout));
        checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int done_cnt;
        logic [WIDTH-1:0] cap_sum;
        logic cap_cout;

        total_checks  = 0;
        passed_checks = 0;
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'h55;
        b     = 8'h66;
        cin   = 1'b1;
        sub   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_sum", 32'(sum), 32'd0);
        checkOutput("reset_cout", 32'(cout), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);

        runAdd("zero", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("zero_done_pulse_low", 32'(done), 32'd0);

        runAdd("ff_plus_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        checkOutput("ff_plus_01_sum_hold", 32'(sum), 32'h00);
        checkOutput("ff_plus_01_cout_hold", 32'(cout), 32'd1);

        runAdd("3c_plus_42", 8'h3C, 8'h42, 1'b0, 1'b0, 8'h7E, 1'b0);

        // Start with new operands during RUN cycle 3 must be ignored.
        applyStimulus(8'h3C, 8'h42, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a     = 8'hFF;
        b     = 8'h01;
        cin   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        cap_sum  = 8'hAA;
        cap_cout = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (done) begin
                done_cnt++;
                cap_sum  = sum;
                cap_cout = cout;
            end
            @(negedge clk);
        end
        checkOutput("ignore_start_done_count", 32'(done_cnt), 32'd1);
        checkOutput("ignore_start_sum", 32'(cap_sum), 32'h7E);
        checkOutput("ignore_start_cout", 32'(cap_cout), 32'd0);

        runAdd("a5_plus_5a_c1", 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1);
        runAdd("back_to_back", 8'hF0, 8'h20, 1'b0, 1'b0, 8'h10, 1'b1);

        // Reset at RUN cycle 4 aborts with no done pulse.
        applyStimulus(8'hFF, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("abort_partial_sum", 32'(sum), 32'hE0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_sum", 32'(sum), 32'd0);
        checkOutput("abort_cout", 32'(cout), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) done_cnt++;
            @(negedge clk);
        end
        checkOutput("abort_no_done", 32'(done_cnt), 32'd0);

`ifdef SERIAL_ADDER_SUB_EN
        runAdd("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
        runAdd("sub_01_02", 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0);
`else
        runAdd("sub_ignored", 8'h10, 8'h01, 1'b0, 1'b1, 8'h11, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition; sampled only in IDLE.
REQ-005 The block SHALL have ports a and b, input, WIDTH bits each: operands, captured on the accepted-start edge.
REQ-006 The block SHALL have port cin, input, 1 bit: carry-in, captured on the accepted-start edge.
REQ-007 The block SHALL have port sub, input, 1 bit: subtract request, captured on the accepted-start edge; used only when the macro in REQ-022 is defined.
REQ-008 The block SHALL have port sum, output, WIDTH bits: the result register.
REQ-009 The block SHALL have port cout, output, 1 bit: the final carry.
REQ-010 The block SHALL have port busy, output, 1 bit: high in RUN.
REQ-011 The block SHALL have port done, output, 1 bit: single-cycle pulse, high in DONE.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, RUN and DONE.
- IDLE->RUN on start=1.
- RUN->DONE after exactly WIDTH bit-steps.
- DONE->IDLE unconditionally after one cycle.
REQ-013 On accept, the block SHALL load the operand shift registers from a and b, load the carry flip-flop from cin, clear sum and clear the bit counter.
REQ-014 Each RUN cycle, the block SHALL add the operand LSBs and the carry flip-flop in one full-adder step.
- The sum bit shifts into sum from the MSB end.
- The operands shift right by one.
- The carry flip-flop takes the adder carry.
- The counter increments.
REQ-015 Latency: if start is accepted at edge k, then done=1 and the final sum and cout SHALL be valid in the cycle after edge k+WIDTH.
REQ-016 sum and cout SHALL hold their values from DONE until the next accepted start.
REQ-017 start asserted in RUN or DONE SHALL be ignored, with no queuing, and operand changes during RUN SHALL have no effect.
REQ-018 The bit counter SHALL be $clog2(WIDTH)+1 bits wide, and WIDTH=1 SHALL complete in 1 RUN cycle.
REQ-019 cout SHALL be the carry out of bit WIDTH-1, and sum SHALL equal (a+b+cin) mod 2^WIDTH.

Reset
REQ-020 rst=1 SHALL force IDLE on the next edge, overriding start.
- sum=0, cout=0, busy=0, done=0, counter=0, operand registers=0.
REQ-021 rst=1 asserted during RUN SHALL abort the operation with no done pulse.

Configuration
REQ-022 With SERIAL_ADDER_SUB_EN defined, sub=1 at accept SHALL load the one's complement of b and force the carry flip-flop to 1, so that sum=(a-b) mod 2^WIDTH and cout=1 means no borrow.
REQ-023 With SERIAL_ADDER_SUB_EN undefined, the sub port SHALL exist but be ignored, and the block SHALL always add.

Structure
REQ-024 The shared package SHALL hold the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-025 The one-bit full adder (inputs a, b, cin; outputs s, c) SHALL be a separate sub-module named full_adder, instantiated once.

Verification
REQ-026 a=0x00, b=0x00, cin=0 -> done at edge k+8 with sum=0x00, cout=0; busy high for 8 cycles.
REQ-027 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0x3C, b=0x42, cin=0 -> sum=0x7E, cout=0.
REQ-028 a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1, then a second start directly after DONE -> accepted from IDLE, correct result.
REQ-029 start pulsed at RUN cycle 3 with new operands -> ignored, first result unchanged, exactly one done pulse.
REQ-030 rst=1 at RUN cycle 4 -> next cycle IDLE, sum=0, cout=0, busy=0, and no done pulse.
REQ-031 With SERIAL_ADDER_SUB_EN: a=0x10, b=0x01, sub=1 -> sum=0x0F, cout=1; a=0x01, b=0x02, sub=1 -> sum=0xFF, cout=0.
